// File: rtl/lobby_bank_sequencer_pkg.sv
// lobby_bank_sequencer_pkg: shared state encoding and BCD nibble width.
package lobby_bank_sequencer_pkg;
  localparam int NIB_W = 4;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SCAN, S_ACCUM, S_DONE} state_t;
endpackage

// File: rtl/lobby_pair_tracker.sv
// lobby_pair_tracker: registered best two-digit pair (first digit earlier than second) over a digit stream.
module lobby_pair_tracker
  import lobby_bank_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             dig_valid,
  input  logic [NIB_W-1:0] dig,
  output logic [6:0]       best,
  output logic             bad_digit
);
  logic [NIB_W-1:0] r_first;
  logic [6:0] r_best;
  logic r_seen;
  logic [NIB_W-1:0] w_d;
  logic [6:0] w_pair;
  assign w_d = (dig > 4'd9) ? 4'd0 : dig;
  assign w_pair = 7'(r_first) * 7'd10 + 7'(w_d);
  assign bad_digit = dig_valid && dig > 4'd9;
  assign best = r_best;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_first <= '0;
      r_best <= '0;
      r_seen <= 1'b0;
    end else if (clr) begin
      r_first <= '0;
      r_best <= '0;
      r_seen <= 1'b0;
    end else if (dig_valid) begin
      if (r_seen && w_pair > r_best) r_best <= w_pair;
      if (w_d > r_first) r_first <= w_d;
      r_seen <= 1'b1;
    end
endmodule

// File: rtl/lobby_bank_sequencer.sv
// lobby_bank_sequencer: streams each ROM bank through one shared pair tracker and sums the bank values.
module lobby_bank_sequencer
  import lobby_bank_sequencer_pkg::*;
#(
  parameter int DIGITS   = 100,
  parameter int BANKS    = 200,
  parameter int ADDR_W   = 8,
  parameter int RESULT_W = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      mem_rd,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [NIB_W*DIGITS-1:0]   mem_data,
  output logic                      bank_valid,
  output logic [6:0]                bank_value,
  output logic                      busy,
  output logic                      finished,
  output logic [RESULT_W-1:0]       result,
  output logic                      err
);
  localparam int CNT_W = $clog2(DIGITS + 1);
  state_t r_state;
  logic [NIB_W*DIGITS-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_bank;
  logic [RESULT_W-1:0] r_result;
  logic r_rd, r_valid, r_busy, r_fin, r_err;
  logic w_bad;
  lobby_pair_tracker u_trk (
    .clk       (clk),
    .rst       (rst),
    .clr       (r_state == S_LOAD),
    .dig_valid (r_state == S_SCAN),
    .dig       (r_shift[NIB_W*DIGITS-1 -: NIB_W]),
    .best      (bank_value),
    .bad_digit (w_bad)
  );
  assign mem_rd = r_rd;
  assign mem_addr = r_bank;
  assign bank_valid = r_valid;
  assign busy = r_busy;
  assign finished = r_fin;
  assign result = r_result;
  assign err = r_err;
  // Outputs are set on the transition into the state that owns them, so they line up with that state.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt <= '0;
      r_bank <= '0;
      r_result <= '0;
      r_rd <= 1'b0;
      r_valid <= 1'b0;
      r_busy <= 1'b0;
      r_fin <= 1'b0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) begin
          r_state <= S_FETCH;
          r_result <= '0;
          r_err <= 1'b0;
          r_bank <= '0;
          r_rd <= 1'b1;
          r_busy <= 1'b1;
          r_fin <= 1'b0;
        end
        S_FETCH: begin
          r_rd <= 1'b0;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_shift <= mem_data;
          r_cnt <= '0;
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          r_shift <= r_shift << NIB_W;
          r_cnt <= r_cnt + 1'b1;
          r_err <= r_err | w_bad;
          if (r_cnt == CNT_W'(DIGITS - 1)) begin
            r_valid <= 1'b1;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          r_valid <= 1'b0;
          r_result <= r_result + RESULT_W'(bank_value);
          if (r_bank == ADDR_W'(BANKS - 1)) begin
            r_busy <= 1'b0;
            r_fin <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_bank <= r_bank + 1'b1;
            r_rd <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_lobby_bank_sequencer.sv
// tb_lobby_bank_sequencer: directed checks of timing, bank values, restart, reset, bad nibbles and wrap.
module tb_lobby_bank_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  logic m_start = 1'b0, m_rd, m_valid, m_busy, m_fin, m_err;
  logic [1:0] m_addr;
  logic [59:0] m_data = '0;
  logic [59:0] rom_m [4];
  logic [6:0] m_val;
  logic [14:0] m_res;
  lobby_bank_sequencer #(.DIGITS(15), .BANKS(4), .ADDR_W(2), .RESULT_W(15)) u_main (
    .clk(clk), .rst(rst), .start(m_start), .mem_rd(m_rd), .mem_addr(m_addr), .mem_data(m_data),
    .bank_valid(m_valid), .bank_value(m_val), .busy(m_busy), .finished(m_fin), .result(m_res), .err(m_err));
  always_ff @(posedge clk) if (m_rd) m_data <= rom_m[m_addr];

  logic e_start = 1'b0, e_rd, e_valid, e_busy, e_fin, e_err;
  logic [1:0] e_addr;
  logic [7:0] e_data = '0;
  logic [7:0] rom_e [4];
  logic [6:0] e_val;
  logic [14:0] e_res;
  lobby_bank_sequencer #(.DIGITS(2), .BANKS(4), .ADDR_W(2), .RESULT_W(15)) u_edge (
    .clk(clk), .rst(rst), .start(e_start), .mem_rd(e_rd), .mem_addr(e_addr), .mem_data(e_data),
    .bank_valid(e_valid), .bank_value(e_val), .busy(e_busy), .finished(e_fin), .result(e_res), .err(e_err));
  always_ff @(posedge clk) if (e_rd) e_data <= rom_e[e_addr];

  logic w_start = 1'b0, w_rd, w_valid, w_busy, w_fin, w_err;
  logic [0:0] w_addr;
  logic [7:0] w_data = '0;
  logic [6:0] w_val;
  logic [6:0] w_res;
  lobby_bank_sequencer #(.DIGITS(2), .BANKS(2), .ADDR_W(1), .RESULT_W(7)) u_wrap (
    .clk(clk), .rst(rst), .start(w_start), .mem_rd(w_rd), .mem_addr(w_addr), .mem_data(w_data),
    .bank_valid(w_valid), .bank_value(w_val), .busy(w_busy), .finished(w_fin), .result(w_res), .err(w_err));
  always_ff @(posedge clk) if (w_rd) w_data <= 8'h99;

  logic s_start = 1'b0, s_rd, s_valid, s_busy, s_fin, s_err;
  logic [0:0] s_addr;
  logic [3:0] s_data = '0;
  logic [6:0] s_val;
  logic [7:0] s_res;
  lobby_bank_sequencer #(.DIGITS(1), .BANKS(1), .ADDR_W(1), .RESULT_W(8)) u_one (
    .clk(clk), .rst(rst), .start(s_start), .mem_rd(s_rd), .mem_addr(s_addr), .mem_data(s_data),
    .bank_valid(s_valid), .bank_value(s_val), .busy(s_busy), .finished(s_fin), .result(s_res), .err(s_err));
  always_ff @(posedge clk) if (s_rd) s_data <= 4'h9;

  task automatic check_main_zero(input string tag);
    checks++;
    if ({m_rd, m_valid, m_busy, m_fin, m_err} !== 5'b0 || m_res !== 15'd0 || m_val !== 7'd0 || m_addr !== 2'd0) begin
      errors++;
      $display("FAIL %s rd/valid/busy/fin/err=%b result=%0d value=%0d addr=%0d, all must be 0", tag,
               {m_rd, m_valid, m_busy, m_fin, m_err}, m_res, m_val, m_addr);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_main_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_main(input int pulse);
    int exp_v [4] = '{98, 89, 78, 92};
    bit ev, er;
    @(negedge clk) m_start = 1'b1;
    for (int n = 1; n <= 75; n++) begin
      @(negedge clk);
      m_start = (pulse != 0 && n == pulse);
      ev = (n % 18 == 0) && n <= 72;
      er = (n % 18 == 1) && n < 72;
      checks++;
      if (m_valid !== ev) begin errors++; $display("FAIL main_bank_valid cycle %0d got %b exp %b", n, m_valid, ev); end
      if (ev) begin
        checks++;
        if (m_val !== 7'(exp_v[n/18-1])) begin errors++; $display("FAIL main_bank_value cycle %0d got %0d exp %0d", n, m_val, exp_v[n/18-1]); end
      end
      checks++;
      if (m_rd !== er) begin errors++; $display("FAIL main_mem_rd cycle %0d got %b exp %b", n, m_rd, er); end
      if (er) begin
        checks++;
        if (m_addr !== 2'((n-1)/18)) begin errors++; $display("FAIL main_mem_addr cycle %0d got %0d exp %0d", n, m_addr, (n-1)/18); end
      end
      checks++;
      if (m_busy !== (n <= 72) || m_fin !== (n >= 73)) begin
        errors++;
        $display("FAIL main_busy_fin cycle %0d got busy=%b fin=%b exp busy=%b fin=%b", n, m_busy, m_fin, n <= 72, n >= 73);
      end
      if (n <= 18) begin
        checks++;
        if (m_res !== 15'd0) begin errors++; $display("FAIL main_result_clear cycle %0d got %0d exp 0", n, m_res); end
      end
      if (n >= 73) begin
        checks++;
        if (m_res !== 15'd357 || m_err !== 1'b0) begin errors++; $display("FAIL main_result cycle %0d got %0d err=%b exp 357 err=0", n, m_res, m_err); end
      end
    end
  endtask

  task automatic test_standard;
    run_main(0);
  endtask

  task automatic test_busy_restart;
    run_main(5);
    run_main(0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk) m_start = 1'b1;
    @(negedge clk) m_start = 1'b0;
    repeat (38) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_main_zero("reset_mid_run");
    @(negedge clk) rst = 1'b0;
    run_main(0);
  endtask

  task automatic run_edge(input bit bad);
    int exp_v [4];
    int sum;
    bit ev;
    rom_e = '{8'h19, 8'h91, 8'h99, bad ? 8'hA9 : 8'h00};
    exp_v = '{19, 91, 99, bad ? 9 : 0};
    sum = bad ? 218 : 209;
    @(negedge clk) e_start = 1'b1;
    for (int n = 1; n <= 23; n++) begin
      @(negedge clk);
      e_start = 1'b0;
      ev = (n % 5 == 0) && n <= 20;
      checks++;
      if (e_valid !== ev) begin errors++; $display("FAIL edge_bank_valid cycle %0d got %b exp %b", n, e_valid, ev); end
      if (ev) begin
        checks++;
        if (e_val !== 7'(exp_v[n/5-1])) begin errors++; $display("FAIL edge_bank_value cycle %0d got %0d exp %0d", n, e_val, exp_v[n/5-1]); end
      end
      if (n == 1) begin
        checks++;
        if (e_err !== 1'b0 || e_fin !== 1'b0 || e_res !== 15'd0 || e_addr !== 2'd0) begin
          errors++;
          $display("FAIL edge_restart got err=%b fin=%b result=%0d addr=%0d exp all 0", e_err, e_fin, e_res, e_addr);
        end
      end
      if (n >= 21) begin
        checks++;
        if (e_fin !== 1'b1 || e_busy !== 1'b0 || e_res !== 15'(sum) || e_err !== bad) begin
          errors++;
          $display("FAIL edge_done cycle %0d got fin=%b busy=%b result=%0d err=%b exp fin=1 busy=0 result=%0d err=%b",
                   n, e_fin, e_busy, e_res, e_err, sum, bad);
        end
      end
    end
  endtask

  task automatic test_edge_banks;
    run_edge(1'b0);
  endtask

  task automatic test_bad_nibble;
    run_edge(1'b1);
    run_edge(1'b0);
  endtask

  task automatic test_wrap;
    bit ev;
    @(negedge clk) w_start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      w_start = 1'b0;
      ev = (n % 5 == 0) && n <= 10;
      checks++;
      if (w_valid !== ev || (ev && w_val !== 7'd99)) begin
        errors++;
        $display("FAIL wrap_bank cycle %0d got valid=%b value=%0d exp valid=%b value=99", n, w_valid, w_val, ev);
      end
      if (w_rd) begin
        checks++;
        if (w_addr !== 1'((n-1)/5)) begin errors++; $display("FAIL wrap_mem_addr cycle %0d got %0d exp %0d", n, w_addr, (n-1)/5); end
      end
      if (n >= 11) begin
        checks++;
        if (w_fin !== 1'b1 || w_res !== 7'd70 || w_err !== 1'b0) begin
          errors++;
          $display("FAIL wrap_result cycle %0d got fin=%b result=%0d err=%b exp fin=1 result=70 err=0", n, w_fin, w_res, w_err);
        end
      end
    end
  endtask

  task automatic test_single_digit;
    @(negedge clk) s_start = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      s_start = 1'b0;
      checks++;
      if (s_valid !== (n == 4) || s_rd !== (n == 1) || s_busy !== (n <= 4) || s_addr !== 1'b0) begin
        errors++;
        $display("FAIL one_timing cycle %0d got valid=%b rd=%b busy=%b addr=%0d", n, s_valid, s_rd, s_busy, s_addr);
      end
      if (n == 4 || n >= 5) begin
        checks++;
        if (s_val !== 7'd0 || (n >= 5 && (s_fin !== 1'b1 || s_res !== 8'd0 || s_err !== 1'b0))) begin
          errors++;
          $display("FAIL one_value cycle %0d got value=%0d fin=%b result=%0d err=%b exp value=0 result=0", n, s_val, s_fin, s_res, s_err);
        end
      end
    end
  endtask

  initial begin
    rom_m = '{60'h987654321111111, 60'h811111111111119, 60'h234234234234278, 60'h818181911112111};
    rom_e = '{8'h19, 8'h91, 8'h99, 8'h00};
    test_reset;
    test_standard;
    test_busy_restart;
    test_reset_mid;
    test_edge_banks;
    test_bad_nibble;
    test_wrap;
    test_single_digit;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lobby_bank_sequencer.md
# lobby_bank_sequencer

Sequencer for the day-3 joltage datapath. It reads battery banks one at a time from a bank ROM and streams each bank's BCD digits, most-significant first, into a per-bank max-pair tracker. It accumulates each bank's best two-digit value into a running total and raises `finished` when all banks are done. It replaces the fully parallel per-bank evaluation with a single time-shared tracker.

## Interface
- `DIGITS`, 100: digits per bank; 4-bit BCD nibbles, most-significant digit in the top nibble.
- `BANKS`, 200: number of banks in the ROM.
- `ADDR_W`, 8: bank address width; must satisfy 2^ADDR_W ≥ BANKS.
- `RESULT_W`, 15: accumulator width, wraps modulo 2^RESULT_W.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begins a run when sampled high in IDLE or DONE.
- `mem_rd`, output, 1: ROM read strobe.
- `mem_addr`, output, ADDR_W: bank index.
- `mem_data`, input, 4*DIGITS: bank word, valid exactly one cycle after `mem_rd`.
- `bank_valid`, output, 1: one-cycle strobe, high while the current bank's value is being added.
- `bank_value`, output, 7: best two-digit value of the current bank, 0–99.
- `busy`, output, 1: high in every state except IDLE and DONE.
- `finished`, output, 1: high in DONE; stays high until the next `start` or `rst`.
- `result`, output, RESULT_W: sum of all bank values; holds its value in DONE.
- `err`, output, 1: sticky; set when any nibble is greater than 9.

## Operation
- **States:** IDLE → FETCH → LOAD → SCAN → ACCUM, then either FETCH (more banks) or DONE.
- **IDLE/DONE:** on `start`, clear `result`, `err` and the bank index, then go to FETCH. Leaving DONE this way drops `finished`.
- **FETCH** (1 cycle): `mem_rd`=1 and `mem_addr`=bank index.
- **LOAD** (1 cycle): capture `mem_data` into the digit shift register and reset the tracker.
- **SCAN** (DIGITS cycles): present the top nibble to the tracker, then shift left by 4.
- **Tracker rule**, for incoming digit d:
  - If at least one digit has been seen: best := max(best, 10·first + d).
  - Then first := max(first, d).
  - Result: best = max over i<j of 10·d_i + d_j.
- **Non-BCD nibble:** treated as 0 and sets `err`.
- **ACCUM** (1 cycle): `bank_valid`=1 and `result` += `bank_value` (zero-extended, wraps). If the bank index equals BANKS-1, go to DONE; otherwise increment the index and go to FETCH.
- **`start` while `busy`:** ignored.
- **DIGITS=1:** `bank_value`=0.
- **Reset values:** state IDLE; `mem_rd`, `bank_valid`, `busy`, `finished` and `err` all 0; `result`, `bank_value` and `mem_addr` all 0.
- **`rst` mid-run:** returns immediately to IDLE with reset values; no partial result is retained.

## Timing
- **Start:** `start` sampled at edge 0 puts FETCH in cycle 1.
- **Per bank:** DIGITS+3 cycles.
- **`bank_valid`** for bank k: cycle (k+1)·(DIGITS+3).
- **`finished` and final `result`:** first visible in cycle BANKS·(DIGITS+3)+1.
- **`mem_rd`:** exactly one pulse per bank, never back-to-back; `mem_addr` is stable during FETCH.
- **`result` update:** visible the cycle after ACCUM.

## Structure
- **Shared package:** the state encoding enum and the BCD nibble width constant.
- **Sub-module `lobby_pair_tracker`:** inputs `clk`, `rst`, `clr`, `dig_valid`, `dig[3:0]`; outputs `best[6:0]` and `bad_digit`. It is a registered max-pair tracker and should be reused by the part-2 variant.
- **Sequencer:** owns the FSM, the digit shift register, the bank counter and the accumulator.

## Test plan
- **Standard example:** DIGITS=15, BANKS=4, ROM = 987654321111111, 811111111111119, 234234234234278, 818181911112111.
  - `bank_value` = 98, 89, 78, 92 on `bank_valid` cycles 18, 36, 54, 72.
  - `result`=357 and `finished`=1 at cycle 73.
- **Edge banks:** all-nines bank → 99; DIGITS=2 bank 19 → 19; bank 91 → 91; all zeros → 0.
- **Busy and restart:** pulse `start` during SCAN → no effect on the count or timing. A second `start` in DONE → `finished` drops, `result` clears, and the same 357 is reproduced.
- **Reset mid-run:** assert `rst` in the SCAN of bank 2 → all outputs return to 0 asynchronously. A new `start` afterwards gives 357.
- **Bad nibble:** inject nibble 0xA → `err`=1 and stays set through DONE; that digit counts as 0.
- **Wrap:** RESULT_W=7, BANKS=2, banks of 99 each → `result`=198 mod 128 = 70.
